serial_alu_ctrl: RTL and testbench

Bit-serial add/subtract controller for the ULA.
- Sequences a single 1-bit full-adder/subtractor cell over WIDTH bits, LSB first, one bit per clock.
- Operand shift registers, carry/borrow flip-flop, bit counter and start/busy/done handshake.
- Gives the ULA multi-bit add/sub with one bit-slice of arithmetic logic.

---
 rtl/serial_alu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial add/subtract controller.
// One full-adder cell is sequenced over WIDTH bits, LSB first, one bit per
// clock, behind a start/busy/done handshake.
// Optional feature macro: SERIAL_ALU_FLAGS_EN adds overflow and zero outputs.

module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
`ifdef SERIAL_ALU_FLAGS_EN
   ,
   output logic             overflow,
   output logic             zero
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             op_q, op_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SERIAL_ALU_FLAGS_EN
   logic             ov_q, ov_d;
   logic             zero_q, zero_d;
`endif

   // Bit-slice datapath signals for the current bit.
   logic ai, bi, sum, c_next;

   // Next-state, datapath and output decode for the IDLE/RUN/DONE sequencer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      result_d = result_q;
      op_d     = op_q;
      c_d      = c_q;
      cout_d   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
      ov_d     = ov_q;
      zero_d   = zero_q;
`endif

      // Subtract feeds inverted B; the +1 comes from the carry preset at accept.
      ai     = a_sr_q[0];
      bi     = b_sr_q[0] ^ op_q;
      sum    = ai ^ bi ^ c_q;
      c_next = (ai & bi) | (ai & c_q) | (bi & c_q);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               op_d    = op;
               c_d     = op;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = {sum, res_sr_q[WIDTH-1:1]};
            c_d      = c_next;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Results become visible only at the completion edge.
               state_d  = ST_DONE;
               result_d = res_sr_d;
               cout_d   = c_next;
`ifdef SERIAL_ALU_FLAGS_EN
               ov_d     = c_q ^ c_next;
               zero_d   = (res_sr_d == '0);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers; asynchronous reset clears all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         result_q <= '0;
         op_q     <= 1'b0;
         c_q      <= 1'b0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
         ov_q     <= 1'b0;
         zero_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         result_q <= result_d;
         op_q     <= op_d;
         c_q      <= c_d;
         cout_q   <= cout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_ALU_FLAGS_EN
         ov_q     <= ov_d;
         zero_q   <= zero_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
   assign overflow  = ov_q;
   assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for serial_alu_ctrl (WIDTH=8).
// Flag outputs are checked when SERIAL_ALU_FLAGS_EN is defined.

module tb_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
   logic         overflow;
   logic         zero;
`endif

   int checks = 0;
   int errors = 0;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
`ifdef SERIAL_ALU_FLAGS_EN
      ,
      .overflow  (overflow),
      .zero      (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #12;
      checks++;
      if ({busy, done, result, carry_out} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b result=%h cout=%b want all 0",
                  busy, done, result, carry_out);
      end
`ifdef SERIAL_ALU_FLAGS_EN
      checks++;
      if ({overflow, zero} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags got ov=%b z=%b want 0 0", overflow, zero);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One operation from IDLE: latency, busy width, held result, final values.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic top, input logic [W-1:0] er, input logic ec,
                         input logic eov, input logic ez, input string name);
      logic [W-1:0] prev;
      logic         held;
      int           n;
      @(negedge clk);
      a = ta; b = tb_v; op = top; start = 1'b1;
      prev = result;
      @(negedge clk);
      start = 1'b0;
      n = 0; held = 1'b1;
      while (busy && n < 20) begin
         n++;
         if (result !== prev || done !== 1'b0) held = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (n != W) begin
         errors++;
         $display("FAIL %s busy_cycles got %0d want %0d", name, n, W);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL %s result_held_during_run got changed want held", name);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_pulse got %b want 1", name, done);
      end
      checks++;
      if (result !== er || carry_out !== ec) begin
         errors++;
         $display("FAIL %s result got %h/c%b want %h/c%b", name, result, carry_out, er, ec);
      end
`ifdef SERIAL_ALU_FLAGS_EN
      checks++;
      if (overflow !== eov || zero !== ez) begin
         errors++;
         $display("FAIL %s flags got ov=%b z=%b want ov=%b z=%b", name, overflow, zero, eov, ez);
      end
`endif
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
      end
   endtask

   task automatic test_add();
      run_op(8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, "add_25_13");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "add_ff_01");
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
   endtask

   task automatic test_sub();
      run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, "sub_10_01");
      run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "sub_00_01");
      run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");
      run_op(8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, "sub_55_55");
   endtask

   // Inputs and start toggled mid-RUN must not disturb the latched operation.
   task automatic test_ignore_midrun();
      int n;
      int pulses;
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         if (n == 3) begin a = 8'hFF; b = 8'hFF; op = 1'b1; start = 1'b1; end
         if (n == 5) start = 1'b0;
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != W || done !== 1'b1) begin
         errors++;
         $display("FAIL midrun_latency got cycles=%0d done=%b want %0d 1", n, done, W);
      end
      checks++;
      if (result !== 8'h4B || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL midrun_result got %h/c%b want 4b/c0", result, carry_out);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midrun_single_done got %0d extra busy/done cycles want 0", pulses);
      end
   endtask

   // start held high: second operation accepted in the DONE cycle.
   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      a = 8'h20; b = 8'h30; op = 1'b1; start = 1'b1;
      @(negedge clk);
      a = 8'hA0; b = 8'h90; op = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != W || result !== 8'hF0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first got n=%0d %h/c%b want n=%0d f0/c0", n, result, carry_out, W);
      end
      n = 1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
      end
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (n != W + 1) begin
         errors++;
         $display("FAIL b2b_period got %0d want %0d", n, W + 1);
      end
      checks++;
      if (result !== 8'h30 || carry_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got %h/c%b want 30/c1", result, carry_out);
      end
`ifdef SERIAL_ALU_FLAGS_EN
      checks++;
      if (overflow !== 1'b1 || zero !== 1'b0) begin
         errors++;
         $display("FAIL b2b_flags got ov=%b z=%b want 1 0", overflow, zero);
      end
`endif
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   // Asynchronous reset in the 4th RUN cycle aborts with no done pulse.
   task automatic test_reset_abort();
      int n;
      int seen;
      @(negedge clk);
      a = 8'h11; b = 8'h22; op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 3) begin
         n++;
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, result, carry_out} !== 11'd0) begin
         errors++;
         $display("FAIL abort_async got busy=%b done=%b result=%h cout=%b want all 0",
                  busy, done, result, carry_out);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d busy/done cycles want 0", seen);
      end
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, "after_abort");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ignore_midrun();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
